dram_cmd_arbiter: RTL and testbench

//   Shares the single DDR2 command port between two clients: the capture write

---
 rtl/dram_arb_pkg.sv | 19 +
 rtl/dram_arb_starve_timer.sv | 29 ++
 rtl/dram_cmd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared encodings and default sizes for the DDR2 command arbiter.
package dram_arb_pkg;

  localparam int unsigned ADX_W_DEF        = 27;
  localparam int unsigned DATA_W_DEF       = 128;
  localparam int unsigned MAX_BURST_DEF    = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 256;
  localparam int unsigned STATE_W          = 2;

  typedef enum logic [STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/dram_arb_starve_timer.sv
// Saturating count of cycles a read has lost to capture writes; raises a force flag at the limit.
module dram_arb_starve_timer #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_rd_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_rd_c = (cnt == CNT_MAX);

endmodule

// File: rtl/dram_cmd_arbiter.sv
// Arbitrates the capture write stream and the readback read stream onto one DDR2 command port.
// Optional grant/starvation counters are built when DRAM_ARB_PERF_EN is defined.
module dram_cmd_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADX_W        = ADX_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_BURST    = MAX_BURST_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               soc_clk,
  input  logic               soc_resetn,
  input  logic               capture_active,
  input  logic               wr_req,
  input  logic [ADX_W-1:0]   wr_adx,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_grant,
  input  logic               rd_req,
  input  logic [ADX_W-1:0]   rd_adx,
  output logic               rd_grant,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_write,
  output logic [ADX_W-1:0]   cmd_adx,
  output logic [DATA_W-1:0]  cmd_wdata,
  output logic [STATE_W-1:0] arb_state
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_wr_grants,
  output logic [31:0]        perf_rd_grants,
  output logic [15:0]        perf_starve_events
`endif
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(MAX_BURST);

  arb_state_e        state, state_next;
  logic [BCNT_W-1:0] burst_cnt;
  logic [BCNT_W-1:0] rd_lim;
  logic              one_shot;
  logic              rr_last;
  logic              force_rd_c;
  logic              slot_free;
  logic              force_go;
  logic              wr_stop;
  logic              rd_stop;
  logic              any_grant;

  assign slot_free = ~cmd_valid | cmd_ready;
  assign force_go  = force_rd_c & rd_req;
  assign any_grant = wr_grant | rd_grant;
  // A forced read burst yields after its single grant.
  assign rd_lim    = one_shot ? BCNT_W'(1) : BURST_MAX;
  assign wr_stop   = (burst_cnt >= BURST_MAX) & ~capture_active & rd_req;
  assign rd_stop   = (burst_cnt >= rd_lim) & wr_req;
  assign arb_state = state;

  dram_arb_starve_timer #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (soc_clk),
    .rst_n      (soc_resetn),
    .inc        (rd_req & ~rd_grant & capture_active),
    .clr        (rd_grant | ~capture_active),
    .force_rd_c (force_rd_c)
  );

  // State register.
  always_ff @(posedge soc_clk or negedge soc_resetn) begin
    if (!soc_resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    if (force_go && slot_free) begin
      state_next = ARB_RD;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (wr_grant)      state_next = ARB_WR;
          else if (rd_grant) state_next = ARB_RD;
        end
        ARB_WR: begin
          if (!wr_req && !rd_req)                 state_next = ARB_IDLE;
          else if (rd_req && (!wr_req || wr_stop)) state_next = ARB_RD;
        end
        ARB_RD: begin
          if (!wr_req && !rd_req)                 state_next = ARB_IDLE;
          else if (wr_req && (!rd_req || rd_stop)) state_next = ARB_WR;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  // Grant outputs; the starvation force overrides every state.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (slot_free) begin
      if (force_go) begin
        rd_grant = 1'b1;
      end else begin
        case (state)
          ARB_IDLE: begin
            if (wr_req && rd_req) begin
              if (capture_active || (rr_last == CMD_READ)) wr_grant = 1'b1;
              else                                         rd_grant = 1'b1;
            end else begin
              wr_grant = wr_req;
              rd_grant = rd_req;
            end
          end
          ARB_WR:  wr_grant = wr_req & ~wr_stop;
          ARB_RD:  rd_grant = rd_req & ~rd_stop;
          default: ;
        endcase
      end
    end
  end

  // Burst bookkeeping, round-robin memory and the command register.
  always_ff @(posedge soc_clk or negedge soc_resetn) begin
    if (!soc_resetn) begin
      burst_cnt <= '0;
      one_shot  <= 1'b0;
      rr_last   <= CMD_READ;
      cmd_valid <= 1'b0;
      cmd_write <= CMD_READ;
      cmd_adx   <= '0;
      cmd_wdata <= '0;
    end else begin
      if (force_go && slot_free) begin
        burst_cnt <= BCNT_W'(1);
        one_shot  <= 1'b1;
      end else if (state_next != state) begin
        burst_cnt <= any_grant ? BCNT_W'(1) : '0;
        one_shot  <= 1'b0;
      end else if (any_grant && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + BCNT_W'(1);
      end

      if (wr_grant) begin
        rr_last   <= CMD_WRITE;
        cmd_valid <= 1'b1;
        cmd_write <= CMD_WRITE;
        cmd_adx   <= wr_adx;
        cmd_wdata <= wr_data;
      end else if (rd_grant) begin
        rr_last   <= CMD_READ;
        cmd_valid <= 1'b1;
        cmd_write <= CMD_READ;
        cmd_adx   <= rd_adx;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

`ifdef DRAM_ARB_PERF_EN
  // Wrapping grant counters and a saturating forced-read counter.
  always_ff @(posedge soc_clk or negedge soc_resetn) begin
    if (!soc_resetn) begin
      perf_wr_grants     <= '0;
      perf_rd_grants     <= '0;
      perf_starve_events <= '0;
    end else begin
      if (wr_grant) perf_wr_grants <= perf_wr_grants + 32'd1;
      if (rd_grant) perf_rd_grants <= perf_rd_grants + 32'd1;
      if (force_go && slot_free && (perf_starve_events != 16'hFFFF))
        perf_starve_events <= perf_starve_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Self-checking bench for dram_cmd_arbiter: IDLE decision table, burst/starvation patterns, stall and reset.
module tb_dram_cmd_arbiter;
  import dram_arb_pkg::*;

  localparam int unsigned ADX_W  = 27;
  localparam int unsigned DATA_W = 128;

  logic              soc_clk = 1'b0;
  logic              soc_resetn;
  logic              capture_active;
  logic              wr_req;
  logic [ADX_W-1:0]  wr_adx;
  logic [DATA_W-1:0] wr_data;
  logic              wr_grant;
  logic              rd_req;
  logic [ADX_W-1:0]  rd_adx;
  logic              rd_grant;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADX_W-1:0]  cmd_adx;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        arb_state;
`ifdef DRAM_ARB_PERF_EN
  logic [31:0]       perf_wr_grants;
  logic [31:0]       perf_rd_grants;
  logic [15:0]       perf_starve_events;
`endif

  dram_cmd_arbiter dut (
    .soc_clk        (soc_clk),
    .soc_resetn     (soc_resetn),
    .capture_active (capture_active),
    .wr_req         (wr_req),
    .wr_adx         (wr_adx),
    .wr_data        (wr_data),
    .wr_grant       (wr_grant),
    .rd_req         (rd_req),
    .rd_adx         (rd_adx),
    .rd_grant       (rd_grant),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_adx        (cmd_adx),
    .cmd_wdata      (cmd_wdata),
    .arb_state      (arb_state)
`ifdef DRAM_ARB_PERF_EN
    ,
    .perf_wr_grants     (perf_wr_grants),
    .perf_rd_grants     (perf_rd_grants),
    .perf_starve_events (perf_starve_events)
`endif
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic              w;
    logic [ADX_W-1:0]  adx;
    logic [DATA_W-1:0] data;
  } exp_cmd_t;

  typedef struct {
    logic       cap;
    logic       w;
    logic       r;
    logic       eg_w;
    logic       eg_r;
    logic [1:0] est;
  } vec_t;

  exp_cmd_t   exp_q[$];
  vec_t       vt[6];
  int         total = 0;
  int         bad   = 0;
  int         wr_left, rd_left, wr_idx, rd_idx;
  logic       s_wg, s_rg, s_valid, prev_grant;
  logic [1:0] s_state;
  logic [1:0] got, want;

  function automatic logic [DATA_W-1:0] mk_data(input int i);
    return {32'hA5A50000 ^ 32'(i), ~32'(i), 32'(i * 7 + 1), 32'hC0DE0000 + 32'(i)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  task automatic drive_clients();
    wr_req  = (wr_left > 0);
    wr_adx  = ADX_W'(32'h0100000 + 32'(wr_idx));
    wr_data = mk_data(wr_idx);
    rd_req  = (rd_left > 0);
    rd_adx  = ADX_W'(32'h0040000 + 32'(rd_idx));
  endtask

  // One clock: sample mid-cycle, score commands, then advance the client models after the edge.
  task automatic cycle();
    exp_cmd_t e;
    @(negedge soc_clk);
    s_wg    = wr_grant;
    s_rg    = rd_grant;
    s_valid = cmd_valid;
    s_state = arb_state;
    chk("one_grant", 128'(wr_grant & rd_grant), 128'(0));
    if (prev_grant) chk("cmd_latency", 128'(cmd_valid), 128'(1));
    if (cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got cmd_valid=1 adx=%0h want no command", cmd_adx);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_write", 128'(cmd_write), 128'(e.w));
        chk("cmd_adx", 128'(cmd_adx), 128'(e.adx));
        if (e.w) chk("cmd_wdata", 128'(cmd_wdata), 128'(e.data));
      end
    end
    if (wr_grant) exp_q.push_back('{1'b1, wr_adx, wr_data});
    if (rd_grant) exp_q.push_back('{1'b0, rd_adx, '0});
    prev_grant = wr_grant | rd_grant;
    @(posedge soc_clk);
    #1;
    if (s_wg) begin wr_idx++; wr_left--; end
    if (s_rg) begin rd_idx++; rd_left--; end
    drive_clients();
  endtask

  task automatic do_reset();
    soc_resetn     = 1'b0;
    wr_left        = 0;
    rd_left        = 0;
    wr_idx         = 0;
    rd_idx         = 0;
    capture_active = 1'b0;
    cmd_ready      = 1'b1;
    drive_clients();
    exp_q.delete();
    prev_grant = 1'b0;
    repeat (2) @(posedge soc_clk);
    @(negedge soc_clk);
    soc_resetn = 1'b1;
    @(posedge soc_clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [1:0] code_of(input logic wg, input logic rg);
    return {wg, rg};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    int   p;
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ARB_WR};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ARB_RD};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ARB_WR};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ARB_WR};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ARB_RD};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE};

    // Reset values, observed while reset is held.
    soc_resetn = 1'b0; capture_active = 1'b0; cmd_ready = 1'b1;
    wr_left = 0; rd_left = 0; wr_idx = 0; rd_idx = 0; prev_grant = 1'b0;
    drive_clients();
    #12;
    chk("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    chk("rst_cmd_write", 128'(cmd_write), 128'(0));
    chk("rst_cmd_adx", 128'(cmd_adx), 128'(0));
    chk("rst_cmd_wdata", 128'(cmd_wdata), 128'(0));
    chk("rst_grants", 128'({wr_grant, rd_grant}), 128'(0));
    chk("rst_state", 128'(arb_state), 128'(ARB_IDLE));

    // IDLE decision table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      capture_active = vt[i].cap;
      wr_left = vt[i].w ? 1 : 0;
      rd_left = vt[i].r ? 1 : 0;
      drive_clients();
      cycle();
      chk($sformatf("vec%0d_wr_grant", i), 128'(s_wg), 128'(vt[i].eg_w));
      chk($sformatf("vec%0d_rd_grant", i), 128'(s_rg), 128'(vt[i].eg_r));
      wr_left = 0; rd_left = 0;
      drive_clients();
      chk($sformatf("vec%0d_state", i), 128'(arb_state), 128'(vt[i].est));
      drain($sformatf("vec%0d_drain", i));
    end

    // Tie after a write goes to the read side.
    do_reset();
    wr_left = 1; drive_clients();
    cycle();
    chk("rr_first_write", 128'(s_wg), 128'(1));
    cycle(); cycle();
    wr_left = 1; rd_left = 1; drive_clients();
    cycle();
    chk("rr_tie_code", 128'(code_of(s_wg, s_rg)), 128'(2'b01));
    wr_left = 0; rd_left = 0; drive_clients();
    drain("rr_drain");

    // 20 back-to-back writes.
    do_reset();
    wr_left = 20; drive_clients();
    for (int c = 0; c < 22; c++) begin
      cycle();
      want = (c < 20) ? 2'b10 : 2'b00;
      chk($sformatf("t1_c%0d", c), 128'(code_of(s_wg, s_rg)), 128'(want));
    end
    drain("t1_drain");

    // Both held without capture: 8 writes, dead, 8 reads, dead.
    do_reset();
    wr_left = 100; rd_left = 100; drive_clients();
    for (int c = 0; c < 54; c++) begin
      cycle();
      p = c % 18;
      want = (p < 8) ? 2'b10 : ((p >= 9 && p <= 16) ? 2'b01 : 2'b00);
      chk($sformatf("t2_c%0d", c), 128'(code_of(s_wg, s_rg)), 128'(want));
    end
    wr_left = 0; rd_left = 0; drive_clients();
    drain("t2_drain");

    // Capture with both held: 256 writes, one forced read, turnaround, writes again.
    do_reset();
    capture_active = 1'b1;
    wr_left = 1000; rd_left = 1000; drive_clients();
    for (int c = 0; c < 300; c++) begin
      cycle();
      want = (c < 256) ? 2'b10 : (c == 256) ? 2'b01 : (c == 257) ? 2'b00 : 2'b10;
      got  = code_of(s_wg, s_rg);
      chk($sformatf("t3_c%0d", c), 128'(got), 128'(want));
    end
    wr_left = 0; rd_left = 0; capture_active = 1'b0; drive_clients();
    drain("t3_drain");

    // Downstream stall: command held, no grants, first grant when ready returns.
    do_reset();
    wr_left = 3; drive_clients();
    cycle();
    chk("t4_first", 128'(s_wg), 128'(1));
    cmd_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk($sformatf("t4_nogrant%0d", k), 128'(code_of(s_wg, s_rg)), 128'(0));
      chk($sformatf("t4_valid%0d", k), 128'(s_valid), 128'(1));
      chk($sformatf("t4_adx%0d", k), 128'(cmd_adx), 128'(exp_q[0].adx));
      chk($sformatf("t4_wdata%0d", k), 128'(cmd_wdata), 128'(exp_q[0].data));
    end
    cmd_ready = 1'b1;
    cycle();
    chk("t4_grant_on_ready", 128'(s_wg), 128'(1));
    cycle();
    chk("t4_last_grant", 128'(s_wg), 128'(1));
    drain("t4_drain");

    // Reset while a read command is held in RD_BURST.
    do_reset();
    wr_left = 1; rd_left = 100; drive_clients();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      found = s_rg;
    end
    chk("t5_read_grant", 128'(found), 128'(1));
    cmd_ready = 1'b0;
    cycle();
    chk("t5_pre_state", 128'(arb_state), 128'(ARB_RD));
    chk("t5_pre_valid", 128'(cmd_valid), 128'(1));
    #2;
    soc_resetn = 1'b0;
    wr_left = 0; rd_left = 0; drive_clients();
    exp_q.delete();
    prev_grant = 1'b0;
    #1;
    chk("t5_valid", 128'(cmd_valid), 128'(0));
    chk("t5_write", 128'(cmd_write), 128'(0));
    chk("t5_adx", 128'(cmd_adx), 128'(0));
    chk("t5_wdata", 128'(cmd_wdata), 128'(0));
    chk("t5_grants", 128'({wr_grant, rd_grant}), 128'(0));
    chk("t5_state", 128'(arb_state), 128'(ARB_IDLE));
    @(negedge soc_clk);
    soc_resetn = 1'b1;
    @(posedge soc_clk);
    #1;
    cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("t5_no_replay%0d", k), 128'(s_valid), 128'(0));
    end

`ifdef DRAM_ARB_PERF_EN
    // Performance counters over 5 writes and 3 reads.
    do_reset();
    wr_left = 5; rd_left = 3; drive_clients();
    for (int k = 0; k < 40 && (wr_left > 0 || rd_left > 0); k++) cycle();
    chk("t6_requests_done", 128'(wr_left + rd_left), 128'(0));
    drain("t6_drain");
    chk("t6_perf_wr", 128'(perf_wr_grants), 128'(5));
    chk("t6_perf_rd", 128'(perf_rd_grants), 128'(3));
    chk("t6_perf_starve", 128'(perf_starve_events), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
